// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a small FIFO of
// fetched {pc, instr} pairs, and redirect handling that discards stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] IR_out,
    output logic        valid_out
);
    localparam int unsigned PW = (QDEPTH > 2) ? 2 : 1;
    localparam int unsigned CW = (QDEPTH > 3) ? 3 : 2;
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(QDEPTH);
    localparam logic [CW-1:0] ROOM_MAX = CW'(QDEPTH - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fpc_q, fpc_d;
    logic [31:0]    imem_addr_q, imem_addr_d;
    logic           imem_req_q, imem_req_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    pc_mem_q [QDEPTH];
    logic [31:0]    ir_mem_q [QDEPTH];

    logic           push;
    logic           pop;
    logic           flush;
    logic [CW-1:0]  occ_after_pop;
    logic [31:0]    target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign valid_out = (count_q != '0);
    assign PC_out    = valid_out ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign IR_out    = valid_out ? ir_mem_q[rd_ptr_q] : 32'h0;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        push          = 1'b0;
        flush         = 1'b0;
        pop           = valid_out && !stall && !redirect;
        occ_after_pop = count_q - CW'(pop);

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fpc_d = target_pc;
                    flush = 1'b1;
                end else if (occ_after_pop < DEPTH_C) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fpc_d   = target_pc;
                    flush   = 1'b1;
                    // Without an ack the old request is still in flight and must be drained.
                    state_d = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    fpc_d   = fpc_q + 32'd4;
                    state_d = (occ_after_pop < ROOM_MAX) ? WAIT : IDLE;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fpc_d = target_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = occ_after_pop + CW'(push);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            end
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
            end
        end

        // DRAIN keeps presenting the abandoned address until its ack arrives.
        imem_req_d = (state_d != IDLE);
        case (state_d)
            WAIT:    imem_addr_d = fpc_d;
            DRAIN:   imem_addr_d = imem_addr_q;
            default: imem_addr_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count_q.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    pc_mem_q[gi] <= fpc_q;
                    ir_mem_q[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked
// against a queue-based model of the fetch rules.
module tb_fetch_unit;
    localparam int          QD  = 3;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] PC_out;
    logic [31:0] IR_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_out(PC_out),
        .IR_out(IR_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    logic [97:0] dut_vec;
    assign dut_vec = {imem_req, imem_addr, valid_out, PC_out, IR_out};

    // Reference model: fetch pointer, one outstanding request, FIFO of fetched pairs.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    logic        m_busy;
    logic        m_drain;

    task automatic model_reset();
        mq.delete();
        m_fpc   = RPC;
        m_addr  = 32'h0;
        m_busy  = 1'b0;
        m_drain = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ak, input logic [31:0] rdat);
        logic pop_ok;
        ent_t e;
        pop_ok = (mq.size() != 0) && !st && !rd;
        if (rd) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else if (pop_ok) begin
            void'(mq.pop_front());
        end
        if (!m_busy) begin
            if (!rd && mq.size() < QD) begin
                m_busy  = 1'b1;
                m_drain = 1'b0;
                m_addr  = m_fpc;
            end
        end else if (m_drain) begin
            if (ak) m_busy = 1'b0;
        end else if (rd) begin
            if (ak) m_busy = 1'b0;
            else    m_drain = 1'b1;
        end else if (ak) begin
            e.pc = m_addr;
            e.ir = rdat;
            mq.push_back(e);
            m_fpc = m_addr + 32'd4;
            if (mq.size() < QD) m_addr = m_fpc;
            else                m_busy = 1'b0;
        end
    endtask

    function automatic logic [97:0] model_vec();
        logic [31:0] a, p, i;
        logic        v;
        a = m_busy ? m_addr : 32'h0;
        v = (mq.size() != 0);
        p = 32'h0;
        i = 32'h0;
        if (v) begin
            p = mq[0].pc;
            i = mq[0].ir;
        end
        return {m_busy, a, v, p, i};
    endfunction

    // One clock: drive inputs away from the edge, step model on the edge, settle.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ak, input logic [31:0] rdat);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ak;
        imem_rdata  = rdat;
        @(posedge clk);
        model_step(st, rd, rpc, ak, rdat);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 98'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec, 98'h0);
        end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RPC}) begin
            errors++;
            $display("FAIL first_request: got req=%b addr=%h expected req=1 addr=%h",
                     imem_req, imem_addr, RPC);
        end
    endtask

    task automatic test_sequential();
        for (int n = 0; n < 12; n++) begin
            cyc(1'b0, 1'b0, 32'h0, m_busy, 32'h1000 + m_addr);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL sequential cyc %0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_stall();
        for (int n = 0; n < 5; n++) begin
            cyc(1'b1, 1'b0, 32'h0, m_busy, 32'h1000 + m_addr);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL stall cyc %0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
        checks++;
        if ({imem_req, valid_out} !== 2'b01) begin
            errors++;
            $display("FAIL stall_full: got req=%b valid=%b expected req=0 valid=1", imem_req, valid_out);
        end
        for (int n = 0; n < 10; n++) begin
            cyc(1'b0, 1'b0, 32'h0, m_busy, 32'h1000 + m_addr);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL stall_release cyc %0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_redirect_wait();
        logic        rd_v [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        ak_v [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 6; n++) begin
            cyc(1'b0, rd_v[n], 32'h0000_0102, ak_v[n], 32'hDEAD_BEEF);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL redirect_wait cyc %0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
        checks++;
        if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            errors++;
            $display("FAIL redirect_target: got req=%b addr=%h valid=%b expected req=1 addr=00000100 valid=0",
                     imem_req, imem_addr, valid_out);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_1100);
        checks++;
        if ({valid_out, PC_out, IR_out} !== {1'b1, 32'h0000_0100, 32'h0000_1100}) begin
            errors++;
            $display("FAIL redirect_first: got valid=%b pc=%h ir=%h expected valid=1 pc=00000100 ir=00001100",
                     valid_out, PC_out, IR_out);
        end
    endtask

    task automatic test_redirect_ack();
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, 1'b0, 32'h0, m_busy, 32'h1000 + m_addr);
        end
        cyc(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h5555_5555);
        checks++;
        if ({imem_req, valid_out, PC_out, IR_out} !== 66'h0) begin
            errors++;
            $display("FAIL redirect_ack_flush: got req=%b valid=%b pc=%h ir=%h expected all zero",
                     imem_req, valid_out, PC_out, IR_out);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("FAIL redirect_ack_target: got req=%b addr=%h expected req=1 addr=00000200",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_align: got addr=%h expected fffffffc", imem_addr);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_ABCD);
        checks++;
        if ({imem_req, imem_addr, PC_out} !== {1'b1, 32'h0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_next: got req=%b addr=%h pc=%h expected req=1 addr=00000000 pc=fffffffc",
                     imem_req, imem_addr, PC_out);
        end
    endtask

    task automatic test_reset_mid();
        logic reached;
        reached = 1'b0;
        cyc(1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        for (int n = 0; n < 20 && !reached; n++) begin
            if (m_busy && !m_drain && mq.size() == 2) reached = 1'b1;
            else cyc(1'b1, 1'b0, 32'h0, m_busy, 32'h2000 + m_addr);
        end
        checks++;
        if (!reached || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_setup: reached=%b got %h expected %h", reached, dut_vec, model_vec());
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 98'h0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got %h expected %h", dut_vec, 98'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
        checks++;
        if ({imem_req, imem_addr, valid_out} !== {1'b1, RPC, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_stray: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                     imem_req, imem_addr, valid_out, RPC);
        end
        for (int n = 0; n < 5; n++) begin
            cyc(1'b0, 1'b0, 32'h0, m_busy, 32'h1000 + m_addr);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL reset_mid_restart cyc %0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic        st, rd, ak;
        logic [31:0] rpc;
        for (int n = 0; n < 400; n++) begin
            st  = ($urandom_range(99) < 30);
            rd  = ($urandom_range(99) < 6);
            rpc = $urandom;
            ak  = m_busy ? ($urandom_range(99) < 55) : ($urandom_range(99) < 10);
            cyc(st, rd, rpc, ak, $urandom);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", n, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
